immgen_pipe: RTL
================

Name: immgen_pipe

Overview:
- Parametrised, registered successor to the ID-stage immediate generator.
- Decodes the immediate of a raw instruction for a selectable format and sign-extends it to XLEN.
- Carries a sideband tag (PC/ROB id) alongside the immediate.
- Delivers the result through a valid/ready handshake with a 2-entry skid buffer, so ID→EX backpressure never drops or duplicates an instruction; supports pipeline flush.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64; sign extension fills bits XLEN-1:32 when 64.
- TAG_W, 32, width of the pass-through tag.
- ZIMM_EN, 1, 1 enables format 5 (CSR zimm); 0 makes format 5 illegal.

Ports:
- clk  in  1  clock, all state rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  block can accept an entry this cycle.
- in_sel  in  3  ImmSel format code.
- in_instr  in  32  raw instruction.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the entry.
- out_imm  out  XLEN  decoded immediate.
- out_tag  out  TAG_W  tag of the output entry.
- out_err  out  1  entry used an illegal selector.

Behaviour:
Format codes, combinational decode, s = instr[31] replicated to XLEN:
- 0 I: s, instr[31:20].
- 1 S: s, instr[31:25], instr[11:7].
- 2 SB: s, instr[7], instr[30:25], instr[11:8], 0.
- 3 UJ: s, instr[19:12], instr[20], instr[30:21], 0.
- 4 U: instr[31:12], 12'b0, sign-extended from bit 31 when XLEN=64.
- 5 ZIMM: zero-extended instr[19:15]; legal only if ZIMM_EN=1.
- 6 SHAMT: zero-extended instr[25:20] if XLEN=64, else instr[24:20].
- 7, or 5 with ZIMM_EN=0: illegal; imm = 0, err = 1.
- All legal codes give err = 0.

Storage: main register M (drives out_*) and skid register K. Each holds valid, imm, tag, err.

Handshake:
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = !K.valid, registered with no combinational path from out_ready.
- Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N if M is empty or M is transferring at edge N.
- If M is full and stalled, the incoming entry is written to K. When M transfers, K moves to M on the same edge and K empties.
- Simultaneous input and output transfer with K empty: the new entry replaces M.
- Order is strictly FIFO; K is never overwritten while valid.
- out_imm, out_tag and out_err hold stable while out_valid && !out_ready.

Flush:
- On a rising edge with flush=1, M.valid and K.valid clear; any input presented that cycle is discarded.
- Flush has priority over all transfers.
- in_ready is 1 the following cycle.

Reset (async, rst_n low):
- out_valid=0, out_imm=0, out_tag=0, out_err=0, in_ready=1 after reset release.
- K cleared.
- Asserting reset mid-stall drops all entries immediately, without waiting for an edge.

Data fields of M and K load only on accepted transfers, not on idle cycles.

Test Plan:
- XLEN=32, out_ready=1, back-to-back entries:
  - sel=0, instr=0xFFF00093 → out_imm=0xFFFFFFFF one cycle later.
  - sel=1, instr=0xFE112E23 → 0xFFFFFFFC.
  - sel=2, instr=0xFE000EE3 → 0xFFFFFFFC.
  - sel=3, instr=0x0080006F → 0x00000008.
  - sel=4, instr=0x123450B7 → 0x12345000.
  - out_tag matches each entry's in_tag.
- XLEN=64:
  - sel=4, instr=0x800000B7 → 0xFFFFFFFF80000000.
  - sel=6, instr=0x03F09093 → 0x000000000000003F.
  - sel=5, instr=0x000FD073 → 0x000000000000001F.
- Backpressure: out_ready=0, send tags A, B.
  - in_ready drops after B; A holds on the outputs.
  - Raise out_ready: A then B appear on consecutive cycles, none lost or repeated.
  - in_ready returns to 1 the cycle after K drains.
- sel=7, and sel=5 with ZIMM_EN=0 → out_err=1, out_imm=0, handshake unaffected.
- Flush with M and K both full plus in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed tags never appear.
- Assert rst_n=0 asynchronously between edges while stalled:
  - out_valid falls immediately, all outputs read 0.
  - After release, the first new entry appears with 1-cycle latency.

Source files
------------

// File: rtl/immgen_pipe.sv
// Registered ID-stage immediate generator: decodes and sign-extends the immediate of a
// raw instruction, carries a sideband tag, and delivers it through a 2-entry skid buffer.
module immgen_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 32,
  parameter bit          ZIMM_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [2:0] SEL_I     = 3'd0;
  localparam logic [2:0] SEL_S     = 3'd1;
  localparam logic [2:0] SEL_SB    = 3'd2;
  localparam logic [2:0] SEL_UJ    = 3'd3;
  localparam logic [2:0] SEL_U     = 3'd4;
  localparam logic [2:0] SEL_ZIMM  = 3'd5;
  localparam logic [2:0] SEL_SHAMT = 3'd6;

  function automatic logic sel_illegal(input logic [2:0] sel);
    logic ill;
    case (sel)
      SEL_I, SEL_S, SEL_SB, SEL_UJ, SEL_U, SEL_SHAMT: ill = 1'b0;
      SEL_ZIMM: ill = (ZIMM_EN == 1'b0);
      default:  ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic [XLEN-1:0] decode_imm(input logic [2:0] sel, input logic [31:0] instr);
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] imm;
    s = {XLEN{instr[31]}};
    imm = {XLEN{1'b0}};
    case (sel)
      SEL_I:  imm = {s[XLEN-1:12], instr[31:20]};
      SEL_S:  imm = {s[XLEN-1:12], instr[31:25], instr[11:7]};
      SEL_SB: imm = {s[XLEN-1:13], instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SEL_UJ: imm = {s[XLEN-1:21], instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      SEL_U: begin
        imm = s;
        imm[31:0] = {instr[31:12], 12'h000};
      end
      SEL_ZIMM: begin
        if (ZIMM_EN) begin
          imm[4:0] = instr[19:15];
        end else begin
          imm = {XLEN{1'b0}};
        end
      end
      SEL_SHAMT: begin
        if (XLEN == 64) begin
          imm[5:0] = instr[25:20];
        end else begin
          imm[4:0] = instr[24:20];
        end
      end
      default: imm = {XLEN{1'b0}};
    endcase
    return imm;
  endfunction

  // Opcode bits carry no immediate information.
  logic opcode_unused_s;
  assign opcode_unused_s = ^in_instr[6:0];

  logic [XLEN-1:0]  dec_imm_s;
  logic             dec_err_s;
  logic             in_xfer_s;
  logic             out_xfer_s;

  logic             m_valid_r, k_valid_r, in_ready_r;
  logic [XLEN-1:0]  m_imm_r, k_imm_r;
  logic [TAG_W-1:0] m_tag_r, k_tag_r;
  logic             m_err_r, k_err_r;

  logic             m_valid_n_s, k_valid_n_s;
  logic             m_load_in_s, m_load_k_s, k_load_in_s;

  assign dec_err_s  = sel_illegal(in_sel);
  assign dec_imm_s  = dec_err_s ? {XLEN{1'b0}} : decode_imm(in_sel, in_instr);
  assign in_xfer_s  = in_valid && in_ready_r;
  assign out_xfer_s = m_valid_r && out_ready;

  // Skid-buffer steering: M refills from K first so order stays FIFO; flush wins.
  always_comb begin
    m_valid_n_s = m_valid_r;
    k_valid_n_s = k_valid_r;
    m_load_in_s = 1'b0;
    m_load_k_s  = 1'b0;
    k_load_in_s = 1'b0;
    if (flush) begin
      m_valid_n_s = 1'b0;
      k_valid_n_s = 1'b0;
    end else if (!m_valid_r || out_xfer_s) begin
      if (k_valid_r) begin
        m_valid_n_s = 1'b1;
        m_load_k_s  = 1'b1;
        k_valid_n_s = 1'b0;
      end else if (in_xfer_s) begin
        m_valid_n_s = 1'b1;
        m_load_in_s = 1'b1;
      end else begin
        m_valid_n_s = 1'b0;
      end
    end else if (in_xfer_s) begin
      k_valid_n_s = 1'b1;
      k_load_in_s = 1'b1;
    end else begin
      k_valid_n_s = k_valid_r;
    end
  end

  // Valid flags and the registered ready, which mirrors the next K occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r  <= 1'b0;
      k_valid_r  <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      m_valid_r  <= m_valid_n_s;
      k_valid_r  <= k_valid_n_s;
      in_ready_r <= !k_valid_n_s;
    end
  end

  // Main entry payload, loaded only when an entry actually moves into M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_imm_r <= {XLEN{1'b0}};
      m_tag_r <= {TAG_W{1'b0}};
      m_err_r <= 1'b0;
    end else if (m_load_k_s) begin
      m_imm_r <= k_imm_r;
      m_tag_r <= k_tag_r;
      m_err_r <= k_err_r;
    end else if (m_load_in_s) begin
      m_imm_r <= dec_imm_s;
      m_tag_r <= in_tag;
      m_err_r <= dec_err_s;
    end else begin
      m_imm_r <= m_imm_r;
      m_tag_r <= m_tag_r;
      m_err_r <= m_err_r;
    end
  end

  // Skid entry payload, loaded only when an input arrives while M is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_imm_r <= {XLEN{1'b0}};
      k_tag_r <= {TAG_W{1'b0}};
      k_err_r <= 1'b0;
    end else if (k_load_in_s) begin
      k_imm_r <= dec_imm_s;
      k_tag_r <= in_tag;
      k_err_r <= dec_err_s;
    end else begin
      k_imm_r <= k_imm_r;
      k_tag_r <= k_tag_r;
      k_err_r <= k_err_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = m_valid_r;
  assign out_imm   = m_imm_r;
  assign out_tag   = m_tag_r;
  assign out_err   = m_err_r;

endmodule
